// File: rtl/calculation_pkg.sv
// Shared types for the calculation unit: operation select, sequencer states
// and divider mode encodings.
package calculation;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    MUL  = 3'd2,
    DIV  = 3'd3,
    SQRT = 3'd4
  } calculation_select;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } seq_state;

  localparam logic DIVIDER_MODE_DIV  = 1'b0;
  localparam logic DIVIDER_MODE_SQRT = 1'b1;

  // Operations that go through the multi-cycle divide/sqrt path.
  function automatic logic is_divider_op(input calculation_select op);
    return (op == DIV) || (op == SQRT);
  endfunction

endpackage

// File: rtl/calc_watchdog.sv
// WAIT-state timeout counter: clears while inactive, counts active cycles and
// flags the cycle in which the TIMEOUT-th active cycle is reached.
module calc_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_active,
  output logic o_expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_active) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds the number of earlier active cycles, so this cycle is number r_count+1.
  assign o_expired = i_active && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/calculation_sequencer.sv
// Issue/complete sequencer for calculation_unit. Build with CALC_SEQ_TIMEOUT_EN
// to add the WAIT-state watchdog that aborts a stuck divide with out_error.
module calculation_sequencer
  import calculation::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  calculation_select i_in_op,
  input  logic [TAG_W-1:0]  i_in_tag,
  output logic              o_operand_load,
  output calculation_select o_calculation_select,
  output logic              o_divider_mode,
  output logic              o_divider_start,
  input  logic              i_busy,
  input  logic              i_done,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [TAG_W-1:0]  o_out_tag,
  output logic              o_out_error
);

  seq_state          r_state, w_next_state, w_accept_state;
  calculation_select r_op;
  logic [TAG_W-1:0]  r_tag;
  logic              w_in_ready, w_accept, w_expired;

  assign w_in_ready = (r_state == IDLE) || ((r_state == RESULT) && i_out_ready);
  assign w_accept   = i_in_valid && w_in_ready;

`ifdef CALC_SEQ_TIMEOUT_EN
  logic r_error;

  calc_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_active (r_state == WAIT),
    .o_expired(w_expired)
  );

  // A done in the expiring cycle wins, so no error is flagged then.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_error <= 1'b0;
    end else if ((r_state == WAIT) && w_expired && !i_done) begin
      r_error <= 1'b1;
    end else if ((r_state == RESULT) && i_out_ready) begin
      r_error <= 1'b0;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_expired        = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_op    <= ADD;
      r_tag   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op  <= i_in_op;
        r_tag <= i_in_tag;
      end
    end
  end

  always_comb begin
    w_accept_state = is_divider_op(i_in_op) ? START : RESULT;
    w_next_state   = r_state;
    case (r_state)
      IDLE:    if (i_in_valid) w_next_state = w_accept_state;
      START:   if (!i_busy) w_next_state = WAIT;
      WAIT:    if (i_done || w_expired) w_next_state = RESULT;
      RESULT:  if (i_out_ready) w_next_state = i_in_valid ? w_accept_state : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_in_ready           = w_in_ready;
    o_operand_load       = w_accept;
    o_calculation_select = r_op;
    o_divider_mode       = (r_op == SQRT) ? DIVIDER_MODE_SQRT : DIVIDER_MODE_DIV;
    o_divider_start      = (r_state == START) && !i_busy;
    o_out_valid          = (r_state == RESULT);
    o_out_tag            = r_tag;
`ifdef CALC_SEQ_TIMEOUT_EN
    o_out_error          = r_error;
`else
    o_out_error          = 1'b0;
`endif
  end

endmodule

// File: doc/calculation_sequencer.md
# calculation_sequencer

Control sequencer for `calculation_unit`. It accepts one operation at a time from the issue stage over a valid/ready handshake, drives `calculation_select`, `divider_mode` and `divider_start`, waits for the multi-cycle divide/sqrt path to finish, and presents the result to the rounding stage over a valid/ready handshake. Single-cycle operations (ADD/SUB/MUL) can issue back-to-back, one per cycle. DIV/SQRT hold the sequencer until `done`.

## Interface
- `TAG_W`, default 4: width of the opaque tag that travels with each operation.
- `TIMEOUT`, default 64: maximum number of WAIT cycles before abort. Used only with `CALC_SEQ_TIMEOUT_EN`.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: an operation is offered.
- `in_ready` out 1: the sequencer accepts the offered operation.
- `in_op` in `calculation::calculation_select`: the requested operation.
- `in_tag` in `TAG_W`: tag for the offered operation.
- `operand_load` out 1: enable for the upstream operand registers that feed `calculation_unit`. Equal to `in_valid & in_ready`.
- `calculation_select` out `calculation::calculation_select`: the latched operation.
- `divider_mode` out 1: 0 = DIV, 1 = SQRT. Valid whenever the latched operation is DIV or SQRT.
- `divider_start` out 1: one-cycle start pulse to the divider.
- `busy` in 1: divider busy.
- `done` in 1: divider done pulse.
- `out_valid` out 1: a result is available.
- `out_ready` in 1: the rounding stage accepts the result.
- `out_tag` out `TAG_W`: tag of the operation whose result is presented.
- `out_error` out 1: the result was aborted by timeout.

## Operation
States: IDLE, START, WAIT, RESULT.

- **IDLE**
  - `in_ready` = 1.
  - On `in_valid`: latch `in_op` and `in_tag`, and assert `operand_load`.
  - ADD, SUB, MUL, or any other encoding → RESULT.
  - DIV or SQRT → START.
- **START**
  - If `busy` = 0: assert `divider_start` for exactly this one cycle, then → WAIT.
  - If `busy` = 1: stay in START with no pulse.
- **WAIT**
  - On `done` = 1 → RESULT.
  - `done` seen in any other state is ignored.
- **RESULT**
  - `out_valid` = 1. `out_tag` and `calculation_select` are held stable until handshake.
  - `in_ready` = `out_ready`, which allows back-to-back issue.
  - On `out_ready` without `in_valid` → IDLE.
  - On `out_ready` with `in_valid`: accept the new operation exactly as in IDLE, taking the same transition.
  - Without `out_ready`: hold all outputs.
- **Data path**
  - The sequencer carries no data path.
  - The rounding stage samples `calculated_fraction`, `calculated_exponent` and `remainder` directly on `out_valid & out_ready`.
  - Operand registers change only on `operand_load`, so the result stays stable through the RESULT hold.
- **Reset mid-operation**
  - Reset → IDLE. Any in-flight operation and its tag are discarded.
  - The divider is reset by the same `reset`.

Output reset values:
- `in_ready` = 1.
- `operand_load`, `divider_start`, `divider_mode`, `out_valid`, `out_error` = 0.
- `out_tag` = 0.
- `calculation_select` = ADD.

## Timing
- Single-cycle operation accepted at edge N: `out_valid` = 1 in cycle N+1.
- Sustained throughput is 1 operation per cycle while `out_ready` = 1.
- DIV/SQRT accepted at edge N: `divider_start` = 1 in cycle N+1, WAIT from N+2.
- `done` high in cycle D: `out_valid` = 1 in cycle D+1.
- Any `out_ready` stall adds cycles one-for-one.
- `divider_start` is never asserted for two consecutive cycles.
- `divider_start` is never asserted while `busy` = 1.

## Configuration
`CALC_SEQ_TIMEOUT_EN` compiles the WAIT watchdog in or out.

- **Defined**
  - A counter cleared on entry to WAIT increments each WAIT cycle.
  - When the count reaches `TIMEOUT` without `done`: → RESULT with `out_error` = 1.
  - `out_error` clears on the handshake.
  - A `done` arriving on the same cycle the count is reached wins: no error is flagged.
- **Not defined**
  - No counter is built. `out_error` is tied to 0 and WAIT waits indefinitely.
  - `TIMEOUT` is unused.

## Structure
- Add the `seq_state` enum (IDLE, START, WAIT, RESULT) to the `calculation` package, alongside `calculation_select`.
- Add the constants `DIVIDER_MODE_DIV` = 0 and `DIVIDER_MODE_SQRT` = 1 to the same package.
- One sub-module, `calc_watchdog` (the timeout counter), instantiated only under `CALC_SEQ_TIMEOUT_EN`.
- The state machine stays in a single `always_ff` with combinational output decode.

## Test plan
- **Reset values:** reset held 3 cycles, then released → all outputs at the reset values above, `in_ready` = 1.
- **Back-to-back single-cycle ops:** ADD tag 1, MUL tag 2, SUB tag 3 offered on consecutive cycles with `out_ready` = 1 → `out_valid` on 3 consecutive cycles, tags 1, 2, 3, `calculation_select` matching each.
- **SQRT with late done:** SQRT tag 5, `done` pulsed 27 cycles after start → `divider_mode` = 1, a single `divider_start` pulse, `out_valid` exactly 1 cycle after `done`, `out_tag` = 5.
- **DIV, start blocked, then stalled output:**
  - Stimulus: DIV offered with `busy` = 1 for 4 cycles; later `out_ready` = 0 for 5 cycles.
  - Required: `divider_start` only after `busy` falls; `in_ready` = 0 throughout; result and tag held stable through the stall.
- **Reset mid-divide:** reset asserted during WAIT → IDLE next cycle; no `out_valid`; a `done` arriving afterwards is ignored.
- **Timeout (`CALC_SEQ_TIMEOUT_EN`, `TIMEOUT` = 8):** DIV with no `done` → `out_valid` with `out_error` = 1 after 8 WAIT cycles; the next ADD returns `out_error` = 0.
